// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width default, mode encoding and edge classification
// used by both the master and slave sides.
package spi_pkg;

    localparam int FRAME_BITS_DEF = 8;

    // Mode number is {CPOL, CPHA}.
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    typedef enum logic [1:0] {
        EDGE_NONE  = 2'b00,
        EDGE_LEAD  = 2'b01,
        EDGE_TRAIL = 2'b10
    } edge_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } slave_state_t;

    // Inputs are SCLK already XORed with CPOL, so idle is always 0.
    function automatic edge_t classify_edge(input logic prev, input logic cur);
        if (!prev && cur)
            return EDGE_LEAD;
        else if (prev && !cur)
            return EDGE_TRAIL;
        else
            return EDGE_NONE;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input bit, with a selectable reset level.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // NOTE: clocked state uses non-blocking assignments so every stage samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++)
                ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave clocked entirely by CLK: SCLK/SS/MOSI are oversampled through synchronizers,
// LSB-first in both directions, all four CPOL/CPHA modes, back-to-back frames.
module spi_slave
    import spi_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CPOL_IN,
    input  logic                  CPHA_IN,
    input  logic                  SCLK_IN,
    input  logic                  SS_IN,
    input  logic                  MOSI_IN,
    output logic                  MISO,
    output logic                  MISO_OE,
    input  logic [FRAME_BITS-1:0] TX_DATA,
    input  logic                  TX_LOAD,
    output logic [FRAME_BITS-1:0] RX_DATA,
    output logic                  RX_VALID,
    input  logic                  RX_READ,
    output logic                  BUSY,
    output logic                  OVERRUN
);

    localparam int CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    logic ss_sync, sclk_norm, mosi_sync;
    logic ss_prev, sclk_prev;
    logic frame_en, ss_fall, sample, shift, last_sample;
    logic unread;
    edge_t sclk_edge;
    slave_state_t state, state_nxt;

    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] tx_hold, tx_shift, rx_shift, rx_next, reload_val;

    // SCLK is normalised against CPOL so its idle (and reset) level is always 0.
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .CLK(CLK), .RST(RST), .d(SS_IN), .q(ss_sync)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .CLK(CLK), .RST(RST), .d(SCLK_IN ^ CPOL_IN), .q(sclk_norm)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .CLK(CLK), .RST(RST), .d(MOSI_IN), .q(mosi_sync)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ss_prev   <= 1'b1;
            sclk_prev <= 1'b0;
            state     <= ST_IDLE;
        end else begin
            ss_prev   <= ss_sync;
            sclk_prev <= sclk_norm;
            state     <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (ss_prev && !ss_sync) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (ss_sync)             state_nxt = ST_IDLE;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_en = 1'b0;
        if (state == ST_ACTIVE && !ss_sync)
            frame_en = 1'b1;
    end

    assign MISO_OE   = frame_en;
    assign ss_fall   = ss_prev && !ss_sync;
    assign sclk_edge = classify_edge(sclk_prev, sclk_norm);
    assign sample    = frame_en && (sclk_edge == (CPHA_IN ? EDGE_TRAIL : EDGE_LEAD));
    // Count 0 means the frame's first bit is already on MISO, so that edge must not shift.
    assign shift       = frame_en && (sclk_edge == (CPHA_IN ? EDGE_LEAD : EDGE_TRAIL)) && (bit_cnt != '0);
    assign last_sample = sample && (bit_cnt == LAST_BIT);
    assign rx_next     = {mosi_sync, rx_shift[FRAME_BITS-1:1]};
    assign reload_val  = TX_LOAD ? TX_DATA : tx_hold;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_hold  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            RX_DATA  <= '0;
            RX_VALID <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            if (TX_LOAD)
                tx_hold <= TX_DATA;
            if (ss_sync) begin
                bit_cnt <= '0;
            end else if (ss_fall) begin
                tx_shift <= reload_val;
                bit_cnt  <= '0;
            end else begin
                if (sample) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= last_sample ? '0 : bit_cnt + 1'b1;
                end
                if (last_sample) begin
                    RX_DATA  <= rx_next;
                    RX_VALID <= 1'b1;
                    tx_shift <= reload_val;
                end else if (shift) begin
                    tx_shift <= tx_shift >> 1;
                end
            end
        end
    end

    // A read acknowledge arriving with the completing frame counts as reading the old one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            unread  <= 1'b0;
            OVERRUN <= 1'b0;
        end else if (last_sample) begin
            if (unread && !RX_READ)
                OVERRUN <= 1'b1;
            unread <= 1'b1;
        end else if (RX_READ) begin
            unread <= 1'b0;
        end
    end

    assign MISO = tx_shift[0];
    assign BUSY = (bit_cnt != '0) || !ss_sync;

endmodule
